// File: rtl/simd_pkg.sv
// simd_pkg: shared types for the SIMD program sequencer (opcodes, instruction layout, FSM states).
package simd_pkg;

    localparam int INS_W  = 64;
    localparam int ADDR_W = 10;

    localparam int OPC_LSB  = 61;
    localparam int PEOP_LSB = 59;
    localparam int A_LSB    = 49;
    localparam int B_LSB    = 39;
    localparam int R_LSB    = 29;
    localparam int IMM_LSB  = 21;
    localparam int CNT_LSB  = 13;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ALU  = 3'd1,
        OP_DOT  = 3'd2,
        OP_LOOP = 3'd3,
        OP_HALT = 3'd4
    } opcode_e;

    localparam logic [1:0] DOT_NONE  = 2'b00;
    localparam logic [1:0] DOT_FIRST = 2'b01;
    localparam logic [1:0] DOT_MID   = 2'b10;
    localparam logic [1:0] DOT_LAST  = 2'b11;

    typedef struct packed {
        logic [INS_W-1-OPC_LSB:0]     opcode;
        logic [OPC_LSB-PEOP_LSB-1:0]  pe_op;
        logic [PEOP_LSB-A_LSB-1:0]    a;
        logic [A_LSB-B_LSB-1:0]       b;
        logic [B_LSB-R_LSB-1:0]       r;
        logic [R_LSB-IMM_LSB-1:0]     imm8;
        logic [IMM_LSB-CNT_LSB-1:0]   cnt8;
        logic [CNT_LSB-1:0]           rsvd;
    } ins_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DONE} state_e;

    // Index of the final DOT element; a length of 0 behaves as 1.
    function automatic logic [7:0] dot_len_m1(input logic [7:0] imm);
        return (imm == 8'd0) ? 8'd0 : imm - 8'd1;
    endfunction

endpackage

// File: rtl/simd_seq_ctrl_dot_expander.sv
// dot_expander: turns one ALU/DOT instruction into its registered per-cycle issue controls.
module dot_expander
    import simd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ins_t              ir,
    input  logic              first,
    input  logic              go,
    input  logic              hold,
    output logic              valid,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [1:0]        pe_op,
    output logic [1:0]        dot_ctrl,
    output logic              write_en,
    output logic              r_select,
    output logic              last
);

    logic [7:0] elem_cnt;
    logic [7:0] k;
    logic [7:0] nm1;
    logic       is_dot;
    logic       k_last;
    logic       load;
    logic       unused_fields;

    assign unused_fields = ^{ir.cnt8, ir.rsvd};

    always_comb begin
        nm1    = dot_len_m1(ir.imm8);
        is_dot = ir.opcode == OP_DOT;
        last   = !is_dot || elem_cnt == nm1;
        load   = first || (go && !hold && !last);
        k      = first ? 8'd0 : elem_cnt + 8'd1;
        k_last = !is_dot || k == nm1;
    end

    // Outputs describe the element being issued this cycle; hold simply keeps them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt <= '0;
            valid    <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            r_addr   <= '0;
            pe_op    <= '0;
            dot_ctrl <= DOT_NONE;
            write_en <= 1'b0;
            r_select <= 1'b0;
        end else if (load) begin
            elem_cnt <= k;
            valid    <= 1'b1;
            a_addr   <= ir.a + ADDR_W'(k);
            b_addr   <= ir.b + ADDR_W'(k);
            r_addr   <= ir.r;
            pe_op    <= ir.pe_op;
            dot_ctrl <= !is_dot ? DOT_NONE : k_last ? DOT_LAST : (k == 8'd0) ? DOT_FIRST : DOT_MID;
            write_en <= k_last;
            r_select <= is_dot && k_last;
        end else if (!(go && hold)) begin
            elem_cnt <= '0;
            valid    <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            r_addr   <= '0;
            pe_op    <= '0;
            dot_ctrl <= DOT_NONE;
            write_en <= 1'b0;
            r_select <= 1'b0;
        end
    end

endmodule

// File: rtl/simd_seq_ctrl.sv
// simd_seq_ctrl: fetch/decode/issue sequencer with DOT expansion, one-level hardware loop and HALT.
module simd_seq_ctrl
    import simd_pkg::*;
#(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int OPCODE_WIDTH   = 3,
    parameter int OP_SEL_WIDTH   = 2,
    parameter int INS_WIDTH      = INS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      hold,
    input  logic [INS_WIDTH-1:0]      ins_rdata,
    output logic                      ins_re,
    output logic [INS_ADDR_WIDTH-1:0] ins_addr,
    output logic                      issue_valid,
    output logic [ADDR_WIDTH-1:0]     a_addr,
    output logic [ADDR_WIDTH-1:0]     b_addr,
    output logic [ADDR_WIDTH-1:0]     r_addr,
    output logic [OP_SEL_WIDTH-1:0]   pe_op,
    output logic [1:0]                dot_ctrl,
    output logic                      write_en,
    output logic                      r_select,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_e                    state, state_n;
    logic [INS_ADDR_WIDTH-1:0] pc, pc_n;
    ins_t                      ir, ir_n, cur;
    logic [OPCODE_WIDTH-1:0]   opc;
    logic [7:0]                loop_cnt, lc_n, eff;
    logic                      loop_active, la_n;
    logic                      err_n;
    logic                      first, go, last;

    dot_expander u_dot (
        .clk      (clk),
        .rst      (rst),
        .ir       (cur),
        .first    (first),
        .go       (go),
        .hold     (hold),
        .valid    (issue_valid),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .r_addr   (r_addr),
        .pe_op    (pe_op),
        .dot_ctrl (dot_ctrl),
        .write_en (write_en),
        .r_select (r_select),
        .last     (last)
    );

    always_comb begin
        cur     = (state == S_DECODE) ? ins_t'(ins_rdata) : ir;
        opc     = cur.opcode;
        eff     = loop_active ? loop_cnt : cur.cnt8;
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        lc_n    = loop_cnt;
        la_n    = loop_active;
        err_n   = err;
        first   = 1'b0;
        go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    pc_n    = '0;
                    err_n   = 1'b0;
                    la_n    = 1'b0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                ir_n = cur;
                case (opc)
                    OP_NOP: begin
                        pc_n    = pc + INS_ADDR_WIDTH'(1);
                        state_n = S_FETCH;
                    end
                    OP_ALU, OP_DOT: begin
                        first   = 1'b1;
                        state_n = S_ISSUE;
                    end
                    OP_LOOP, OP_HALT: state_n = S_ISSUE;
                    default: begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                endcase
            end
            S_ISSUE: begin
                go = opc == OP_ALU || opc == OP_DOT;
                if (!hold) begin
                    case (opc)
                        // A zero effective count falls through and closes the loop.
                        OP_LOOP: begin
                            la_n    = eff != 8'd0;
                            lc_n    = (eff != 8'd0) ? eff - 8'd1 : eff;
                            pc_n    = (eff != 8'd0) ? INS_ADDR_WIDTH'(cur.imm8) : pc + INS_ADDR_WIDTH'(1);
                            state_n = S_FETCH;
                        end
                        OP_HALT: state_n = S_DONE;
                        default: begin
                            if (last) begin
                                pc_n    = pc + INS_ADDR_WIDTH'(1);
                                state_n = S_FETCH;
                            end
                        end
                    endcase
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ins_re      <= 1'b0;
            ins_addr    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ir          <= ir_n;
            loop_cnt    <= lc_n;
            loop_active <= la_n;
            err         <= err_n;
            busy        <= state_n == S_FETCH || state_n == S_DECODE || state_n == S_ISSUE;
            done        <= state_n == S_DONE;
            ins_re      <= state_n == S_FETCH;
            ins_addr    <= pc_n;
        end
    end

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// tb_simd_seq_ctrl: directed programs checked against an instruction-level model of the sequencer.
module tb_simd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [63:0] ins_rdata = '0;
    logic        ins_re;
    logic [7:0]  ins_addr;
    logic        issue_valid;
    logic [9:0]  a_addr, b_addr, r_addr;
    logic [1:0]  pe_op, dot_ctrl;
    logic        write_en, r_select, busy, done, err;

    simd_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold        (hold),
        .ins_rdata   (ins_rdata),
        .ins_re      (ins_re),
        .ins_addr    (ins_addr),
        .issue_valid (issue_valid),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .r_addr      (r_addr),
        .pe_op       (pe_op),
        .dot_ctrl    (dot_ctrl),
        .write_en    (write_en),
        .r_select    (r_select),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    always @(posedge clk) if (ins_re) ins_rdata <= mem[ins_addr];

    int          checks = 0, failures = 0;
    logic [35:0] exp_q [$];
    logic [35:0] last_exp = '0;
    int          exp_total, exp_we, nissued, pop_idx, hold_idx, hold_left, nvalid, nwe;
    bit          exp_err, exp_la, active = 1'b0, held = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [63:0] mk(int op, int pe, int a, int b, int r, int imm, int cnt);
        return {op[2:0], pe[1:0], a[9:0], b[9:0], r[9:0], imm[7:0], cnt[7:0], 13'd0};
    endfunction

    function automatic logic [35:0] pk(int a, int b, int r, int pe, int dc, int we, int rs);
        return {a[9:0], b[9:0], r[9:0], pe[1:0], dc[1:0], we[0], rs[0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = mk(4, 0, 0, 0, 0, 0, 0);
    endtask

    // Executes the program instruction by instruction and lists every issue cycle it must produce.
    task automatic build_model();
        logic [7:0]  pc;
        logic [63:0] w;
        bit          la;
        int          lc, op, pe, a, b, r, imm, cnt, n;
        exp_q.delete();
        exp_err = 0;
        exp_we = 0;
        pc = 0;
        la = 0;
        lc = 0;
        for (int s = 0; s < 4000; s++) begin
            w = mem[pc];
            op = int'(w[63:61]); pe = int'(w[60:59]); a = int'(w[58:49]); b = int'(w[48:39]);
            r = int'(w[38:29]); imm = int'(w[28:21]); cnt = int'(w[20:13]);
            if (op == 4) break;
            if (op > 4) begin exp_err = 1; break; end
            if (op == 1) begin exp_q.push_back(pk(a, b, r, pe, 0, 1, 0)); exp_we++; end
            if (op == 2) begin
                n = (imm == 0) ? 1 : imm;
                for (int k = 0; k < n; k++)
                    exp_q.push_back(pk((a + k) % 1024, (b + k) % 1024, r, pe,
                                       (k == n - 1) ? 3 : (k == 0) ? 1 : 2, k == n - 1, k == n - 1));
                exp_we++;
            end
            if (op == 3) begin
                if (!la) begin la = 1; lc = cnt; end
                if (lc != 0) begin lc--; pc = imm[7:0]; continue; end
                la = 0;
            end
            pc++;
        end
        exp_la = la;
        exp_total = exp_q.size();
    endtask

    initial forever begin
        @(negedge clk);
        if (active) begin
            if (issue_valid) begin
                nvalid++;
                if (write_en) nwe++;
                if (held) chk("issue_held", pk(a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en, r_select), last_exp);
                else begin
                    nissued++;
                    if (exp_q.size() == 0) chk("issue_count", nissued, exp_total);
                    else begin
                        last_exp = exp_q.pop_front();
                        pop_idx++;
                        chk("issue", pk(a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en, r_select), last_exp);
                    end
                end
                if (pop_idx == hold_idx && hold_left > 0) begin hold = 1'b1; hold_left--; end
                else hold = 1'b0;
            end else begin
                chk("idle_ctrl", {write_en, r_select, dot_ctrl}, 4'h0);
                hold = 1'b0;
            end
            held = hold;
        end
    end

    task automatic prep(input int hi, input int hl);
        build_model();
        pop_idx = -1; nissued = 0; nvalid = 0; nwe = 0;
        hold_idx = hi; hold_left = hl; held = 1'b0;
        active = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_prog(input string nm, input int hi, input int hl);
        bit got_done;
        prep(hi, hl);
        chk({nm, "_fetch0"}, {ins_re, ins_addr, busy, err}, {1'b1, 8'd0, 1'b1, 1'b0});
        got_done = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
        end
        chk({nm, "_done_seen"}, got_done, 1);
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_left_unissued"}, exp_q.size(), 0);
        chk({nm, "_we_count"}, nwe, exp_we);
        chk({nm, "_loop_active"}, dut.loop_active, exp_la);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        active = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_outputs", {ins_re, ins_addr, issue_valid, a_addr, b_addr, r_addr, pe_op, dot_ctrl,
                              write_en, r_select, busy, done, err}, 49'd0);
        rst = 1'b0;

        clear_mem();
        mem[0] = mk(1, 2, 5, 6, 7, 0, 0);
        build_model();
        chk("alu_model_pin", exp_q[0], pk(5, 6, 7, 2, 0, 1, 0));
        run_prog("alu", -1, 0);
        chk("alu_issue_cycles", nvalid, 1);

        clear_mem();
        mem[0] = mk(2, 0, 1020, 0, 9, 5, 0);
        build_model();
        chk("dot_model_first", exp_q[0], pk(1020, 0, 9, 0, 1, 0, 0));
        chk("dot_model_wrap", exp_q[4], pk(0, 4, 9, 0, 3, 1, 1));
        run_prog("dot_hold", 3, 2);
        chk("dot_hold_cycles", nvalid, 7);
        chk("dot_single_write", nwe, 1);

        clear_mem();
        mem[0] = mk(2, 1, 100, 200, 3, 0, 0);
        run_prog("dot_n0", -1, 0);
        chk("dot_n0_cycles", nvalid, 1);
        mem[0] = mk(2, 3, 1023, 1023, 4, 1, 0);
        build_model();
        chk("dot_n1_model_pin", exp_q[0], pk(1023, 1023, 4, 3, 3, 1, 1));
        run_prog("dot_n1", -1, 0);
        chk("dot_n1_cycles", nvalid, 1);

        clear_mem();
        mem[0] = mk(1, 1, 1, 2, 3, 0, 0);
        mem[1] = mk(3, 0, 0, 0, 0, 0, 3);
        build_model();
        chk("loop_model_pin", exp_total, 4);
        run_prog("loop", -1, 0);
        chk("loop_alu_cycles", nvalid, 4);

        clear_mem();
        mem[0] = mk(1, 0, 11, 12, 13, 0, 0);
        mem[1] = mk(0, 0, 0, 0, 0, 0, 0);
        mem[2] = mk(6, 0, 0, 0, 0, 0, 0);
        build_model();
        chk("illegal_model_pin", {exp_err, 8'(exp_total)}, {1'b1, 8'd1});
        run_prog("illegal", -1, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        clear_mem();
        run_prog("after_err", -1, 0);

        clear_mem();
        mem[0] = mk(2, 1, 10, 20, 30, 5, 0);
        prep(-1, 0);
        for (int c = 0; c < 200 && pop_idx != 2; c++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_reached_elem2", pop_idx, 2);
        active = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_dot_outputs", {ins_re, ins_addr, issue_valid, a_addr, b_addr, r_addr, pe_op, dot_ctrl,
                                    write_en, r_select, busy, done, err}, 49'd0);
        chk("rst_mid_dot_state", dut.state, simd_pkg::S_IDLE);
        #1 rst = 1'b0;
        run_prog("rerun_after_rst", -1, 0);
        chk("rerun_cycles", nvalid, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
